// File: rtl/m_dmem_latency_model_pkg.sv
// Shared types and helpers for the data-memory latency model.
// Holds FSM state encodings, default latencies and the byte-lane merge.
package m_dmem_latency_model_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    localparam int DMEM_READ_LAT  = 4;
    localparam int DMEM_WRITE_LAT = 2;
    localparam int DMEM_HIT_LAT   = 0;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       en
    );
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/m_dmem_bytearray.sv
// DEPTH x DATA_WIDTH storage, async read port, byte-enabled write port.
// Ports: clk, we (byte enables), waddr, wdata, raddr, rdata.
module m_dmem_bytearray
    import m_dmem_latency_model_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                    clk,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [DEPTH_LOG2-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DEPTH_LOG2-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            mem[waddr][8*b +: 8] <= byte_merge(mem[waddr][8*b +: 8],
                                               wdata[8*b +: 8], we[b]);
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/m_dmem_latency_model.sv
// Data-memory model with DRAM-like latency, open-row hits, init port
// and a saturating stall counter. Ports: init, request, data, stall, count.
module m_dmem_latency_model
    import m_dmem_latency_model_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 9,
    parameter int ROW_LOG2   = 2,
    parameter int READ_LAT   = DMEM_READ_LAT,
    parameter int WRITE_LAT  = DMEM_WRITE_LAT,
    parameter int HIT_LAT    = DMEM_HIT_LAT
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_dmem_init_done,
    input  logic [DATA_WIDTH/8-1:0] i_dmem_init_wen,
    input  logic [ADDR_WIDTH-1:0]   i_dmem_init_addr,
    input  logic [DATA_WIDTH-1:0]   i_dmem_init_data,
    input  logic                    i_dmem_ren,
    input  logic [DATA_WIDTH/8-1:0] i_dmem_wen,
    input  logic [ADDR_WIDTH-1:0]   i_dmem_addr,
    input  logic [DATA_WIDTH-1:0]   i_dmem_data,
    output logic [DATA_WIDTH-1:0]   o_dmem_data,
    output logic                    o_dmem_stall,
    output logic [31:0]             o_stall_cnt
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int ROW_W = DEPTH_LOG2 - ROW_LOG2;

    dmem_state_e state, state_nxt;

    logic [DEPTH_LOG2-1:0] idx;
    logic [ROW_W-1:0]      row;
    logic                  is_wr;
    logic                  start;
    logic                  hit;
    logic [31:0]           lat;
    logic                  fast;
    logic                  slow;

    logic                  row_vld;
    logic [ROW_W-1:0]      open_row;
    logic [DATA_WIDTH-1:0] rdata;
    logic [31:0]           stall_cnt;
    logic [31:0]           cnt;
    logic [DEPTH_LOG2-1:0] held_idx;
    logic [ROW_W-1:0]      held_row;
    logic [DATA_WIDTH-1:0] held_data;
    logic [BE_W-1:0]       held_wen;
    logic                  held_wr;

    logic [BE_W-1:0]       we;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DEPTH_LOG2-1:0] raddr;
    logic [DATA_WIDTH-1:0] arr_rdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_dmem_addr[ADDR_WIDTH-1:DEPTH_LOG2+2],
                                i_dmem_addr[1:0],
                                i_dmem_init_addr[ADDR_WIDTH-1:DEPTH_LOG2+2],
                                i_dmem_init_addr[1:0]};

    assign idx   = i_dmem_addr[DEPTH_LOG2+1:2];
    assign row   = i_dmem_addr[DEPTH_LOG2+1:ROW_LOG2+2];
    assign is_wr = |i_dmem_wen;
    // New requests are only taken from IDLE, outside reset and init.
    assign start = ~i_rst & i_dmem_init_done & (state == DMEM_IDLE)
                 & (i_dmem_ren | is_wr);
    assign hit   = row_vld && (row == open_row);
    assign lat   = hit   ? 32'(HIT_LAT)
                 : is_wr ? 32'(WRITE_LAT)
                 :         32'(READ_LAT);
    assign fast  = start & (lat == 32'd0);
    assign slow  = start & (lat != 32'd0);

    // Outside IDLE the array is addressed by the held request.
    assign raddr = (state == DMEM_IDLE) ? idx : held_idx;

    always_comb begin
        we    = '0;
        waddr = idx;
        wdata = i_dmem_data;
        if (!i_dmem_init_done) begin
            we    = i_dmem_init_wen;
            waddr = i_dmem_init_addr[DEPTH_LOG2+1:2];
            wdata = i_dmem_init_data;
        end else if (fast && is_wr) begin
            we = i_dmem_wen;
        end else if (state == DMEM_DONE && held_wr && !i_rst) begin
            we    = held_wen;
            waddr = held_idx;
            wdata = held_data;
        end
    end

    m_dmem_bytearray #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (i_clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (arr_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= DMEM_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DMEM_IDLE: begin
                if (slow)
                    state_nxt = (lat == 32'd1) ? DMEM_DONE : DMEM_WAIT;
            end
            DMEM_WAIT: begin
                if (cnt <= 32'd1) state_nxt = DMEM_DONE;
            end
            DMEM_DONE: state_nxt = DMEM_IDLE;
            default:   state_nxt = DMEM_IDLE;
        endcase
    end

    always_comb begin
        o_dmem_stall = slow | ((state == DMEM_WAIT) & ~i_rst);
        o_dmem_data  = (fast && !is_wr) ? arr_rdata : rdata;
        o_stall_cnt  = stall_cnt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_vld   <= 1'b0;
            open_row  <= '0;
            rdata     <= '0;
            stall_cnt <= '0;
            cnt       <= '0;
            held_idx  <= '0;
            held_row  <= '0;
            held_data <= '0;
            held_wen  <= '0;
            held_wr   <= 1'b0;
        end else begin
            if (o_dmem_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (fast) begin
                row_vld  <= 1'b1;
                open_row <= row;
                if (!is_wr) rdata <= arr_rdata;
            end
            if (slow) begin
                held_idx  <= idx;
                held_row  <= row;
                held_data <= i_dmem_data;
                held_wen  <= i_dmem_wen;
                held_wr   <= is_wr;
                cnt       <= lat - 32'd1;
                if (lat == 32'd1 && !is_wr) rdata <= arr_rdata;
            end
            // Read data is captured on the last stall cycle so it is
            // registered by the time DONE releases the core.
            if (state == DMEM_WAIT) begin
                cnt <= cnt - 32'd1;
                if (cnt <= 32'd1 && !held_wr) rdata <= arr_rdata;
            end
            if (state == DMEM_DONE) begin
                row_vld  <= 1'b1;
                open_row <= held_row;
            end
        end
    end

endmodule
